sort_input_buffer: RTL and testbench

//  Packet input stage directly upstream of the bubble sorter (bsorter). Captures one
//  sop/eop-framed stream packet into a 2**AWIDTH-word RAM, then hands it to the sorter
//  (do_work pulse + last-word index) and serves its sequential read requests.

---
 rtl/sort_input_buffer.sv | 122 ++++++++++++
 tb/tb_sort_input_buffer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sort_input_buffer.sv
// Packet capture buffer in front of the bubble sorter: stores one sop/eop packet,
// hands it off with do_work_o, then serves sequential reads. Optional stats: SORT_IBUF_STATS_EN.
module sort_input_buffer #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              sop_i,
    input  logic              eop_i,
    input  logic              val_i,
    output logic              busy_o,
    output logic              do_work_o,
    output logic [AWIDTH-1:0] wrpntr_o,
    input  logic              rd_req_i,
    output logic [DWIDTH-1:0] rd_data_o,
    output logic              rd_val_o,
    input  logic              sort_done_i,
    output logic              ovf_o
`ifdef SORT_IBUF_STATS_EN
    ,
    output logic [15:0]       pkt_cnt_o,
    output logic [15:0]       drop_cnt_o
`endif
);

    localparam int DEPTH = 2 ** AWIDTH;
    localparam logic [1:0] IDLE = 2'd0, FILL = 2'd1, HAND = 2'd2, SORT = 2'd3;
    localparam logic [AWIDTH:0] PTR_ONE = 1;

    logic [1:0]        state;
    logic [DWIDTH-1:0] mem [DEPTH];
    // One extra bit so a full buffer (DEPTH words) is distinct from an empty one
    logic [AWIDTH:0]   wr_ptr, rd_ptr;
    logic              full, start, restart, hand, trunc, rd_hit, wr_en;
    logic [AWIDTH-1:0] wr_addr;

    assign full    = wr_ptr[AWIDTH];
    assign start   = (state == IDLE) && val_i && sop_i;
    assign restart = (state == FILL) && val_i && sop_i;
    assign hand    = eop_i && (start || ((state == FILL) && val_i));
    assign trunc   = (state == FILL) && val_i && !sop_i && eop_i && full;
    assign rd_hit  = (state == SORT) && rd_req_i && (rd_ptr <= {1'b0, wrpntr_o});
    assign wr_en   = start || restart || ((state == FILL) && val_i && !full);
    assign wr_addr = (start || restart) ? '0 : wr_ptr[AWIDTH-1:0];

    always_ff @(posedge clk_i) begin
        if (wr_en)
            mem[wr_addr] <= data_i;
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            busy_o    <= 1'b0;
            do_work_o <= 1'b0;
            wrpntr_o  <= '0;
            rd_data_o <= '0;
            rd_val_o  <= 1'b0;
            ovf_o     <= 1'b0;
        end else begin
            do_work_o <= hand;
            ovf_o     <= trunc;
            rd_val_o  <= rd_hit;
            if (rd_hit) begin
                rd_data_o <= mem[rd_ptr[AWIDTH-1:0]];
                rd_ptr    <= rd_ptr + PTR_ONE;
            end
            case (state)
                IDLE, FILL: begin
                    if (start || restart) begin
                        wr_ptr <= PTR_ONE;
                        state  <= FILL;
                    end else if ((state == FILL) && val_i && !full) begin
                        wr_ptr <= wr_ptr + PTR_ONE;
                    end
                    if (hand) begin
                        state  <= HAND;
                        busy_o <= 1'b1;
                        if (start || restart)
                            wrpntr_o <= '0;
                        else if (full)
                            wrpntr_o <= AWIDTH'(DEPTH - 1);
                        else
                            wrpntr_o <= wr_ptr[AWIDTH-1:0];
                    end
                end
                HAND: begin
                    state  <= SORT;
                    rd_ptr <= '0;
                end
                SORT: begin
                    // A read issued together with sort_done_i still completes above
                    if (sort_done_i) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        wr_ptr <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SORT_IBUF_STATS_EN
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            pkt_cnt_o  <= '0;
            drop_cnt_o <= '0;
        end else begin
            if (hand)
                pkt_cnt_o <= pkt_cnt_o + 16'd1;
            if (restart || trunc)
                drop_cnt_o <= drop_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sort_input_buffer.sv
// Self-checking bench for sort_input_buffer: vector table, hand-written corner cases,
// and randomized packets checked against a queue-based packet model.
module tb_sort_input_buffer;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    logic          clk = 0;
    logic          srst_i = 0;
    logic [DW-1:0] data_i = '0;
    logic          sop_i = 0, eop_i = 0, val_i = 0;
    logic          busy_o, do_work_o;
    logic [AW-1:0] wrpntr_o;
    logic          rd_req_i = 0;
    logic [DW-1:0] rd_data_o;
    logic          rd_val_o;
    logic          sort_done_i = 0;
    logic          ovf_o;

    sort_input_buffer #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk_i(clk), .srst_i(srst_i), .data_i(data_i), .sop_i(sop_i), .eop_i(eop_i),
        .val_i(val_i), .busy_o(busy_o), .do_work_o(do_work_o), .wrpntr_o(wrpntr_o),
        .rd_req_i(rd_req_i), .rd_data_o(rd_data_o), .rd_val_o(rd_val_o),
        .sort_done_i(sort_done_i), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [DW-1:0] d; bit sop; bit eop; } word_t;
    typedef struct { int len; int sop2; int last; bit ovf; } vec_t;

    int checks = 0;
    int errors = 0;
    word_t q[$];
    logic [DW-1:0] exp_q[$];
    vec_t vt[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic add(input logic [DW-1:0] d, input bit s, input bit e);
        word_t w;
        w.d = d; w.sop = s; w.eop = e;
        q.push_back(w);
    endtask

    task automatic send(input bit gaps);
        foreach (q[i]) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin val_i = 0; step(); end
            data_i = q[i].d; sop_i = q[i].sop; eop_i = q[i].eop; val_i = 1;
            step();
        end
        val_i = 0; sop_i = 0; eop_i = 0;
    endtask

    task automatic check_hand(input string name, input int last, input bit ovf);
        chk({name, ".do_work"}, int'(do_work_o), 1);
        chk({name, ".wrpntr"}, int'(wrpntr_o), last);
        chk({name, ".ovf"}, int'(ovf_o), int'(ovf));
        chk({name, ".busy"}, int'(busy_o), 1);
        step();
        chk({name, ".do_work_end"}, int'(do_work_o), 0);
        chk({name, ".ovf_end"}, int'(ovf_o), 0);
        chk({name, ".busy_hold"}, int'(busy_o), 1);
    endtask

    // Reads come back one cycle after each request; requests past the packet end get rd_val_o=0
    task automatic do_reads(input string name, input int nreq, input bit rnd);
        int issued = 0;
        int idx = 0;
        for (int c = 0; issued < nreq && c < 400; c++) begin
            bit r;
            r = !rnd || ($urandom_range(0, 1) == 1);
            rd_req_i = r;
            step();
            if (r) begin
                issued++;
                if (idx < exp_q.size()) begin
                    chk({name, ".rd_val"}, int'(rd_val_o), 1);
                    chk({name, ".rd_data"}, int'(rd_data_o), int'(exp_q[idx]));
                    idx++;
                end else begin
                    chk({name, ".rd_val_past_end"}, int'(rd_val_o), 0);
                end
            end else begin
                chk({name, ".rd_val_idle"}, int'(rd_val_o), 0);
            end
        end
        rd_req_i = 0;
        chk({name, ".reads_issued"}, issued, nreq);
    endtask

    task automatic finish_sort(input string name);
        sort_done_i = 1;
        step();
        sort_done_i = 0;
        chk({name, ".busy_release"}, int'(busy_o), 0);
    endtask

    initial begin
        // Reset state
        srst_i = 1; step(); step(); srst_i = 0;
        chk("rst.busy", int'(busy_o), 0);
        chk("rst.do_work", int'(do_work_o), 0);
        chk("rst.wrpntr", int'(wrpntr_o), 0);
        chk("rst.rd_data", int'(rd_data_o), 0);
        chk("rst.rd_val", int'(rd_val_o), 0);
        chk("rst.ovf", int'(ovf_o), 0);

        // Test 1: 5,3,9,1, last read issued together with sort_done_i
        q.delete(); add(8'd5, 1, 0); add(8'd3, 0, 0); add(8'd9, 0, 0); add(8'd1, 0, 1);
        send(0);
        check_hand("t1", 3, 0);
        exp_q = {8'd5, 8'd3, 8'd9};
        do_reads("t1", 3, 0);
        rd_req_i = 1; sort_done_i = 1; step(); rd_req_i = 0; sort_done_i = 0;
        chk("t1.done_rd_val", int'(rd_val_o), 1);
        chk("t1.done_rd_data", int'(rd_data_o), 1);
        chk("t1.done_busy", int'(busy_o), 0);

        // IDLE: reads ignored, val without sop ignored even with eop
        rd_req_i = 1; step(); rd_req_i = 0;
        chk("idle.rd_val", int'(rd_val_o), 0);
        data_i = 8'h33; val_i = 1; eop_i = 1; step(); val_i = 0; eop_i = 0;
        chk("idle.nosop_do_work", int'(do_work_o), 0);
        chk("idle.nosop_busy", int'(busy_o), 0);
        step();
        chk("idle.nosop_busy2", int'(busy_o), 0);

        // Test 2 + 5: single word, then a word offered while busy must be ignored
        q.delete(); add(8'hAA, 1, 1);
        send(0);
        check_hand("t2", 0, 0);
        data_i = 8'h77; sop_i = 1; eop_i = 1; val_i = 1; step();
        val_i = 0; sop_i = 0; eop_i = 0;
        chk("t5.busy_ignore_do_work", int'(do_work_o), 0);
        chk("t5.busy_ignore_busy", int'(busy_o), 1);
        exp_q = {8'hAA};
        do_reads("t2", 2, 0);
        finish_sort("t2");
        q.delete(); add(8'h11, 1, 0); add(8'h22, 0, 1);
        send(0);
        check_hand("t5", 1, 0);
        exp_q = {8'h11, 8'h22};
        do_reads("t5", 3, 0);
        finish_sort("t5");

        // Test 6: reset in SORT with a read in flight
        q.delete(); add(8'h41, 1, 0); add(8'h42, 0, 0); add(8'h43, 0, 1);
        send(0);
        check_hand("t6", 2, 0);
        exp_q = {8'h41};
        do_reads("t6", 1, 0);
        rd_req_i = 1; srst_i = 1; step(); rd_req_i = 0; srst_i = 0;
        chk("t6.busy", int'(busy_o), 0);
        chk("t6.do_work", int'(do_work_o), 0);
        chk("t6.wrpntr", int'(wrpntr_o), 0);
        chk("t6.rd_data", int'(rd_data_o), 0);
        chk("t6.rd_val", int'(rd_val_o), 0);
        chk("t6.ovf", int'(ovf_o), 0);
        q.delete(); add(8'h51, 1, 0); add(8'h52, 0, 1);
        send(0);
        check_hand("t6b", 1, 0);
        exp_q = {8'h51, 8'h52};
        do_reads("t6b", 2, 0);
        finish_sort("t6b");

        // Vector table: length, second-sop position (-1 none), expected last index, expected ovf
        vt[0] = '{4, -1, 3, 1'b0};
        vt[1] = '{1, -1, 0, 1'b0};
        vt[2] = '{20, -1, 15, 1'b1};
        vt[3] = '{5, 3, 1, 1'b0};
        vt[4] = '{16, -1, 15, 1'b0};
        vt[5] = '{17, -1, 15, 1'b1};
        vt[6] = '{10, 9, 0, 1'b0};
        vt[7] = '{2, -1, 1, 1'b0};
        for (int v = 0; v < 8; v++) begin
            int st;
            string nm;
            nm = $sformatf("vec%0d", v);
            q.delete();
            for (int i = 0; i < vt[v].len; i++)
                add(8'(v * 29 + i * 7 + 3), (i == 0) || (i == vt[v].sop2), i == vt[v].len - 1);
            send(0);
            check_hand(nm, vt[v].last, vt[v].ovf);
            st = (vt[v].sop2 < 0) ? 0 : vt[v].sop2;
            exp_q.delete();
            for (int i = 0; i <= vt[v].last; i++) exp_q.push_back(q[st + i].d);
            do_reads(nm, vt[v].last + 2, 0);
            finish_sort(nm);
        end

        // Randomized packets against a packet-level model
        for (int it = 0; it < 25; it++) begin
            int len, st, keep;
            bit ovf;
            string nm;
            nm = $sformatf("rnd%0d", it);
            q.delete();
            repeat ($urandom_range(0, 2)) add(8'($urandom), 0, $urandom_range(0, 1) == 1);
            len = $urandom_range(1, 20);
            st = 0;
            if (len > 1 && $urandom_range(0, 3) == 0) st = $urandom_range(1, len - 1);
            for (int i = 0; i < len; i++)
                add(8'($urandom), (i == 0) || (i == st), i == len - 1);
            // Retained words: those from the last sop onward, capped at the buffer depth
            keep = (len - st > DEPTH) ? DEPTH : len - st;
            ovf = (len - st) > DEPTH;
            exp_q.delete();
            for (int i = 0; i < keep; i++) exp_q.push_back(q[q.size() - len + st + i].d);
            send(1);
            check_hand(nm, keep - 1, ovf);
            do_reads(nm, keep + $urandom_range(0, 2), 1);
            finish_sort(nm);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
